mul_seq_16bit: RTL
==================

# mul_seq_16bit

Sequential 16×16 unsigned multiplier that drives one shared `add_sub_16bit` instance through a shift-and-add sequence. It takes operands over a valid/ready handshake, runs 16 iterations, and returns a 32-bit product over a second valid/ready handshake. It sits beside the combinational ALU as the multi-cycle MUL unit and reuses the existing adder instead of adding a dedicated multiplier array.

## Interface
- Parameters: none. Operand width is fixed at 16 and iteration count at 16.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: unit idle and able to accept operands.
- `in_a` in 16: multiplicand.
- `in_b` in 16: multiplier.
- `out_valid` out 1: `product` valid; held until accepted.
- `out_ready` in 1: consumer accepts `product`.
- `product` out 32: unsigned `in_a * in_b`.
- `busy` out 1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE when the iteration counter reaches 15.
  - DONE → IDLE on `out_valid && out_ready`.
- Registers:
  - `mcand[15:0]`
  - `acc[15:0]` (upper product)
  - `q[15:0]` (lower product and multiplier)
  - `cnt[3:0]`
- On accept: `mcand`←`in_a`, `q`←`in_b`, `acc`←0, `cnt`←0.
- Each RUN cycle:
  - The adder computes `acc + mcand` with `sel`=0 and produces `{cout,sum}`.
  - If `q[0]`=1: `{acc,q}` ← `{cout,sum,q[15:1]}`.
  - Else: `{acc,q}` ← `{1'b0,acc,q[15:1]}`.
  - `cnt` increments.
- After 16 iterations the product is `{acc,q}`. `product` is driven directly from `{acc,q}` in DONE and is 0 in every other state.
- The adder's `sel` input is tied to 0 in this block. Subtraction capability stays unused and is reserved for a later divider.
- `in_ready` = (state==IDLE). `busy` = !`in_ready`. `out_valid` = (state==DONE).
- `in_valid` is ignored in RUN and DONE, and operands are not captured. The upstream side must hold its request until `in_ready`.
- `in_a`/`in_b` may change freely after the accept edge; results depend only on the captured values.
- Zero operands still take the full 16 iterations; there is no early termination.
- Overflow is impossible: the 32-bit result always fits.

## Timing
- Reset (`rst_n` low, any time, including mid-RUN or in DONE):
  - state=IDLE, all registers 0.
  - `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0.
  - An in-flight operation is discarded with no output.
- Latency:
  - Accept edge E0.
  - RUN occupies the cycles between E0 and E16.
  - `out_valid` rises immediately after edge E16 (16 clocks after accept).
- `out_valid` and `product` stay stable while `out_ready`=0, for an unbounded time.
- If `out_ready` is already high when `out_valid` rises, the handshake completes on the next edge (E17), giving 1 DONE cycle minimum.
- `in_ready` rises the cycle after the output handshake. There is no same-edge output-accept/input-accept overlap. Maximum throughput is one result per 18 cycles.
- The adder path is combinational within one cycle: `acc`→`add_sub_16bit`→`acc`.

## Structure
- Shared header `alu_defs.vh` holds:
  - FSM state encodings (`MUL_IDLE`=2'd0, `MUL_RUN`=2'd1, `MUL_DONE`=2'd2).
  - `ALU_W`=16.
  - `MUL_ITER`=16.
- One sub-module: `add_sub_16bit`, with `in0`=`acc`, `in1`=`mcand`, `sel`=0, and `sum`/`cout` feeding the shift logic.
- Everything else (FSM, counter, shift registers) is flat in `mul_seq_16bit`.

## Test plan
- Reset then idle: `rst_n` low mid-stream → `in_ready`=1, `out_valid`=0, `product`=0x00000000.
- Basic: a=0x0003, b=0x0005, `out_ready`=1 → `out_valid` exactly 16 cycles after accept, `product`=0x0000000F, then `in_ready` returns.
- Extremes: a=0xFFFF, b=0xFFFF → 0xFFFE0001. a=0x1234, b=0x0000 → 0x00000000 after the full 16 cycles.
- Backpressure: a=0x00FF, b=0x0100, `out_ready` held 0 for 10 cycles → `product`=0x0000FF00 held stable and `in_ready`=0 throughout.
- Ignored request: new `in_valid` with a=0x0002, b=0x0002 asserted during RUN of a=0x0010, b=0x0010 → first result 0x00000100. The second is accepted only after `in_ready` rises, then yields 0x00000004.
- Reset mid-RUN: `rst_n` pulsed low at iteration 7 of a=0xABCD, b=0x1234 → no `out_valid`. The next operation a=0x0007, b=0x0006 returns 0x0000002A.

Source files
------------

// File: rtl/mul_seq_16bit_pkg.sv
// Shared constants for the sequential multiplier: FSM encodings, datapath width, iteration count.
package mul_seq_16bit_pkg;

  localparam int ALU_W    = 16;
  localparam int MUL_ITER = 16;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  localparam logic [3:0] MUL_CNT_LAST = 4'(MUL_ITER - 1);

endpackage

// File: rtl/add_sub_16bit.sv
// Combinational 16-bit adder/subtractor: sel=0 gives in0+in1, sel=1 gives in0-in1; cout is the carry out.
// Zero latency; no flow control.
module add_sub_16bit
  import mul_seq_16bit_pkg::*;
(
  input  logic [ALU_W-1:0] in0,
  input  logic [ALU_W-1:0] in1,
  input  logic             sel,
  output logic [ALU_W-1:0] sum,
  output logic             cout
);

  logic [ALU_W-1:0] in1_eff;

  // Subtraction as in0 + ~in1 + 1.
  assign in1_eff     = sel ? ~in1 : in1;
  assign {cout, sum} = {1'b0, in0} + {1'b0, in1_eff} + {{ALU_W{1'b0}}, sel};

endmodule

// File: rtl/mul_seq_16bit.sv
// Shift-and-add 16x16 unsigned multiplier on the shared adder; result valid 16 clocks after accept.
// Operands are taken only when idle; the product is held in DONE until out_ready.
module mul_seq_16bit
  import mul_seq_16bit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALU_W-1:0]   in_a,
  input  logic [ALU_W-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*ALU_W-1:0] product,
  output logic               busy
);

  logic [1:0]       state;
  logic [ALU_W-1:0] mcand;
  logic [ALU_W-1:0] acc;
  logic [ALU_W-1:0] q;
  logic [3:0]       cnt;
  logic [ALU_W-1:0] sum;
  logic             cout;

  // The subtract path is kept free for a future divider sharing this adder.
  add_sub_16bit u_add_sub (
    .in0  (acc),
    .in1  (mcand),
    .sel  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign in_ready  = (state == MUL_IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state == MUL_DONE);
  assign product   = out_valid ? {acc, q} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MUL_IDLE;
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (in_valid) begin
            mcand <= in_a;
            q     <= in_b;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          // q shifts out multiplier bits at the bottom while product bits enter from acc.
          if (q[0]) {acc, q} <= {cout, sum, q[ALU_W-1:1]};
          else      {acc, q} <= {1'b0, acc, q[ALU_W-1:1]};
          cnt <= cnt + 4'd1;
          if (cnt == MUL_CNT_LAST) state <= MUL_DONE;
        end
        MUL_DONE: begin
          if (out_ready) state <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

endmodule
